uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `TxUnit` between `NREQ` byte producers. It accepts one byte from the winning requester and drives the unit's `data_in`/`send`. It then tracks `tx_active`/`tx_done` until the frame completes and reports completion back to the owner. Frame format inputs (`parity_type`, `baud_rate`, `stop_bits`, `data_length`) stay global and are driven outside this block.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `TIMEOUT_CYCLES`, 1048575: watchdog limit in `clock` cycles. Used only when the watchdog is compiled in.
- `clock` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: per-requester request level. Held with data until `gnt`.
- `req_data` in 8*NREQ: byte `i` is at bits [8i+7:8i].
- `gnt` out NREQ: one-cycle pulse; byte was latched.
- `done` out NREQ: one-cycle pulse to the owner when its frame has finished.
- `err` out 1: one-cycle pulse on watchdog expiry.
- `busy` out 1: high in every state except IDLE.
- `owner` out 3: index of the current or last granted requester.
- `tx_data` out 8: connects to `TxUnit.data_in`. Stable from grant until the frame completes.
- `tx_send` out 1: connects to `TxUnit.send`.
- `tx_active` in 1, `tx_done` in 1: driven from `TxUnit`.

## Operation
- States: IDLE, SEND, WAIT_DONE, GAP.
- **IDLE**
  - If `req` is nonzero, pick the first set bit searching upward from `ptr`, wrapping modulo NREQ.
  - Latch that requester's byte into `tx_data`, set `owner`, pulse `gnt[owner]`, go to SEND.
- **SEND**
  - `tx_send` is 1.
  - When `tx_active`=1 is sampled: `tx_send` goes to 0 on the next edge, go to WAIT_DONE.
- **WAIT_DONE**
  - When `tx_done`=1 is sampled: pulse `done[owner]`, set `ptr` to (owner+1) mod NREQ, go to GAP.
- **GAP**
  - Stay while `tx_done`=1, so a level-style `tx_done` is never double-counted.
  - Go to IDLE when `tx_done`=0. This costs at least one cycle.
- **Requester rules**
  - Dropping `req` before `gnt` withdraws the request without side effects.
  - `req` sampled in the same cycle as `gnt` is ignored for the next arbitration only if the requester drops it. A requester that keeps `req` high re-enters arbitration at lower priority.
- **Fairness**
  - `ptr` advances only on completion or on watchdog expiry.
  - Any continuously requesting requester is granted within NREQ frames.
- **Simultaneous events**
  - `tx_active` and `tx_done` both high while in SEND: go to WAIT_DONE. Completion is then taken on the next cycle.
  - `gnt` and `done` are never high in the same cycle.

## Timing
- **Reset values:** `gnt`=0, `done`=0, `err`=0, `busy`=0, `owner`=0, `tx_data`=8'h00, `tx_send`=0, `ptr`=0, state=IDLE.
- **Reset asserted mid-frame:** all outputs return to reset values immediately (asynchronous). No `done` is issued.
- **Grant latency:** `req` sampled in IDLE at edge N gives `gnt`, `tx_send`=1 and valid `tx_data` after edge N.
- **Send release:** `tx_send` drops after the edge that samples `tx_active`=1.
- **Done latency:** `done` pulses in the cycle after the edge that samples `tx_done`=1.
- **Minimum spacing:** at least 2 cycles between `done` and the next `gnt` (GAP plus IDLE).
- **All outputs are registered.** Nothing combinational runs from input to output.

## Configuration
- **`UART_TX_ARB_WATCHDOG_EN` defined**
  - A 20-bit counter clears on entering SEND and counts during SEND and WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES`: pulse `err`, force `tx_send`=0, advance `ptr` past `owner`, go to IDLE.
  - No `done` is issued for that frame.
- **Not defined**
  - No counter is built and `err` is tied to 0.
  - The block waits indefinitely in SEND or WAIT_DONE.

## Test plan
- **Single request:** `req`=4'b0100, `req_data` byte2=8'hA5 → `gnt`=4'b0100 for 1 cycle, `tx_data`=8'hA5, `tx_send` high until `tx_active`. On `tx_done`, `done`=4'b0100 for 1 cycle; `busy` low 2 cycles later.
- **Round-robin:** `req`=4'b1111 held for 8 frames → grant order 0,1,2,3,0,1,2,3. Each `done` matches its `gnt` index.
- **Withdraw:** req0 raised and then dropped while req1's frame is in progress → req0 never receives `gnt`. Next grant goes to whichever requester is still requesting.
- **Level `tx_done`:** `tx_done` held high 5 cycles after the frame → exactly one `done` pulse. The next `gnt` comes no earlier than 2 cycles after `tx_done` falls.
- **Async reset mid-frame:** `rst` pulsed during WAIT_DONE → `tx_send`=0, `busy`=0, `tx_data`=0 without waiting for a clock edge. After release, `req`=4'b0011 is granted to index 0.
- **Watchdog** (macro on, `TIMEOUT_CYCLES`=100): `tx_active` never asserted → `err` pulses once about 100 cycles after `gnt`, no `done`, and the next grant goes to owner+1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one TxUnit between NREQ byte producers.
// Define UART_TX_ARB_WATCHDOG_EN to build the SEND/WAIT_DONE watchdog that drives err.
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic [2:0]        owner,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_active,
  input  logic              tx_done
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;
  state_t state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [2:0] owner_q, owner_d, ptr_q, ptr_d, pick, nxt;
  logic [7:0] tx_data_q, tx_data_d, req_pad;
  logic [63:0] data_pad;
  logic tx_send_q, tx_send_d, found, timeout;
  assign req_pad  = 8'(req);
  assign data_pad = 64'(req_data);
  assign nxt      = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
  // Descending scan so the requester closest above ptr wins.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_pad[3'((32'(ptr_q) + 32'(k)) % NREQ)]) begin
        pick  = 3'((32'(ptr_q) + 32'(k)) % NREQ);
        found = 1'b1;
      end
    end
  end
`ifdef UART_TX_ARB_WATCHDOG_EN
  logic [19:0] cnt_q, cnt_d;
  logic err_q;
  assign timeout = (state_q == SEND || state_q == WAIT_DONE) && cnt_q == 20'(TIMEOUT_CYCLES);
  assign cnt_d   = (state_q == IDLE) ? 20'd0 : (state_q == GAP) ? cnt_q : cnt_q + 20'd1;
  assign err     = err_q;
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^20'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    done_d    = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    tx_send_d = tx_send_q;
    case (state_q)
      IDLE: if (found) begin
        state_d   = SEND;
        owner_d   = pick;
        gnt_d     = NREQ'(1) << pick;
        tx_data_d = data_pad[{pick, 3'b000} +: 8];
        tx_send_d = 1'b1;
      end
      SEND: if (tx_active) begin
        state_d   = WAIT_DONE;
        tx_send_d = 1'b0;
      end
      WAIT_DONE: if (tx_done) begin
        state_d = GAP;
        done_d  = NREQ'(1) << owner_q;
        ptr_d   = nxt;
      end
      default: if (!tx_done) state_d = IDLE;
    endcase
    if (timeout) begin
      state_d   = IDLE;
      done_d    = '0;
      tx_send_d = 1'b0;
      ptr_d     = nxt;
    end
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
    end
  end
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = state_q != IDLE;
  assign owner   = owner_q;
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter; grants checked against a round-robin model.
module tb_uart_tx_arbiter;
  logic clock = 1'b0, rst = 1'b0, tx_active = 1'b0, tx_done = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] gnt, done;
  logic err, busy, tx_send;
  logic [2:0] owner;
  logic [7:0] tx_data;
  int checks = 0, fails = 0, bptr = 0;
  typedef struct {int idx; logic [7:0] data;} exp_t;
  exp_t sb[$];
  always #5 clock = ~clock;
  uart_tx_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .err(err), .busy(busy), .owner(owner), .tx_data(tx_data), .tx_send(tx_send),
    .tx_active(tx_active), .tx_done(tx_done));
  function automatic int arb(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  function automatic logic [7:0] byte_of(input int i);
    logic [31:0] v;
    v = req_data >> (8 * i);
    return v[7:0];
  endfunction
  task automatic push_exp(input logic [3:0] r);
    exp_t e;
    e.idx = arb(r, bptr);
    e.data = byte_of(e.idx);
    sb.push_back(e);
  endtask
  task automatic start_frame(input logic [3:0] drop, output logic [3:0] g, output logic [7:0] d, output logic s, output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (gnt === 4'b0 && n < 30);
    g = gnt; d = tx_data; s = tx_send;
    req = req & ~(drop & gnt);
  endtask
  task automatic finish_frame(input int act_delay, input int done_len, output logic s_hold, output logic s_after,
                              output logic [3:0] dn, output int dcnt, output logic clash);
    repeat (act_delay) @(negedge clock);
    s_hold = tx_send;
    tx_active = 1'b1;
    @(negedge clock);
    tx_active = 1'b0;
    s_after = tx_send;
    tx_done = 1'b1;
    dn = '0; dcnt = 0; clash = 1'b0;
    for (int k = 1; k <= done_len + 1; k++) begin
      @(negedge clock);
      if (done !== 4'b0) begin dcnt++; dn |= done; if (gnt !== 4'b0) clash = 1'b1; end
      if (k == done_len) tx_done = 1'b0;
    end
  endtask
  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (gnt !== 4'b0) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (done !== 4'b0) begin fails++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== 3'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", owner); end
    checks++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_send !== 1'b0) begin fails++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
    rst = 1'b0;
    bptr = 0;
  endtask
  task automatic test_round_robin;
    logic [3:0] g, dn; logic [7:0] d; logic s, sh, sa, cl; int n, dc; exp_t e;
    req_data = 32'h4332_2110;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push_exp(req);
      start_frame(4'b0000, g, d, s, n);
      e = sb.pop_front();
      checks++; if (g !== 4'(1 << e.idx)) begin fails++; $display("FAIL rr_gnt[%0d]: got %b want idx %0d", i, g, e.idx); end
      checks++; if (d !== e.data) begin fails++; $display("FAIL rr_data[%0d]: got %h want %h", i, d, e.data); end
      finish_frame(0, 1, sh, sa, dn, dc, cl);
      checks++; if (dn !== 4'(1 << e.idx) || dc != 1 || cl) begin fails++; $display("FAIL rr_done[%0d]: got %b x%0d clash %b want idx %0d x1", i, dn, dc, cl, e.idx); end
      bptr = (e.idx + 1) % 4;
    end
    req = '0;
  endtask
  task automatic test_single;
    logic [3:0] g, dn; logic [7:0] d; logic s, sh, sa, cl; int n, dc; exp_t e;
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    push_exp(req);
    start_frame(4'b1111, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx)) begin fails++; $display("FAIL single_gnt: got %b want idx %0d", g, e.idx); end
    checks++; if (d !== e.data) begin fails++; $display("FAIL single_data: got %h want %h", d, e.data); end
    checks++; if (s !== 1'b1 || n != 1) begin fails++; $display("FAIL single_latency: send %b after %0d cycles want 1 after 1", s, n); end
    @(negedge clock);
    checks++; if (gnt !== 4'b0) begin fails++; $display("FAIL single_gnt_pulse: got %b want 0000", gnt); end
    finish_frame(1, 1, sh, sa, dn, dc, cl);
    checks++; if (sh !== 1'b1 || sa !== 1'b0) begin fails++; $display("FAIL single_send: hold %b after %b want 1 then 0", sh, sa); end
    checks++; if (dn !== 4'(1 << e.idx) || dc != 1) begin fails++; $display("FAIL single_done: got %b x%0d want idx %0d x1", dn, dc, e.idx); end
    checks++; if (busy !== 1'b0 || owner !== 3'(e.idx) || err !== 1'b0) begin fails++; $display("FAIL single_end: busy %b owner %0d err %b want 0 %0d 0", busy, owner, err, e.idx); end
    bptr = (e.idx + 1) % 4;
  endtask
  task automatic test_withdraw;
    logic [3:0] g, dn; logic [7:0] d; logic s, sh, sa, cl; int n, dc; exp_t e;
    req_data = 32'h9900_7700;
    req = 4'b0010;
    push_exp(req);
    start_frame(4'b1111, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx)) begin fails++; $display("FAIL wd_gnt1: got %b want idx %0d", g, e.idx); end
    req[0] = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (gnt !== 4'b0) begin fails++; $display("FAIL wd_no_gnt: got %b want 0000", gnt); end
    req = 4'b1000;
    finish_frame(0, 1, sh, sa, dn, dc, cl);
    checks++; if (dn !== 4'(1 << e.idx) || dc != 1) begin fails++; $display("FAIL wd_done1: got %b x%0d want idx %0d", dn, dc, e.idx); end
    bptr = (e.idx + 1) % 4;
    push_exp(req);
    start_frame(4'b1111, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx) || d !== e.data) begin fails++; $display("FAIL wd_gnt2: got %b/%h want idx %0d/%h", g, d, e.idx, e.data); end
    finish_frame(0, 1, sh, sa, dn, dc, cl);
    bptr = (e.idx + 1) % 4;
  endtask
  task automatic test_level_done;
    logic [3:0] g, dn; logic [7:0] d; logic s, sh, sa, cl; int n, dc; exp_t e;
    req_data = 32'h0000_3C11;
    req = 4'b0001;
    push_exp(req);
    start_frame(4'b1111, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx)) begin fails++; $display("FAIL lvl_gnt1: got %b want idx %0d", g, e.idx); end
    req = 4'b0010;
    finish_frame(0, 5, sh, sa, dn, dc, cl);
    checks++; if (dn !== 4'(1 << e.idx) || dc != 1 || cl) begin fails++; $display("FAIL lvl_done: got %b x%0d clash %b want idx %0d x1", dn, dc, cl, e.idx); end
    bptr = (e.idx + 1) % 4;
    push_exp(req);
    start_frame(4'b1111, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx) || d !== e.data) begin fails++; $display("FAIL lvl_gnt2: got %b/%h want idx %0d/%h", g, d, e.idx, e.data); end
    checks++; if (n + 1 < 2) begin fails++; $display("FAIL lvl_spacing: got %0d cycles want >= 2", n + 1); end
    finish_frame(0, 1, sh, sa, dn, dc, cl);
    bptr = (e.idx + 1) % 4;
  endtask
  task automatic test_async_reset;
    logic [3:0] g, dn; logic [7:0] d; logic s, sh, sa, cl; int n, dc; exp_t e;
    req_data = 32'h005A_0000;
    req = 4'b0100;
    push_exp(req);
    start_frame(4'b1111, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx) || d !== e.data) begin fails++; $display("FAIL ar_gnt: got %b/%h want idx %0d/%h", g, d, e.idx, e.data); end
    tx_active = 1'b1;
    @(negedge clock);
    tx_active = 1'b0;
    checks++; if (busy !== 1'b1 || tx_send !== 1'b0) begin fails++; $display("FAIL ar_wait_state: busy %b send %b want 1 0", busy, tx_send); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || tx_data !== 8'h00 || tx_send !== 1'b0 || owner !== 3'd0) begin fails++; $display("FAIL ar_async: busy %b data %h send %b owner %0d want 0 00 0 0", busy, tx_data, tx_send, owner); end
    @(negedge clock);
    checks++; if (done !== 4'b0) begin fails++; $display("FAIL ar_no_done: got %b want 0000", done); end
    rst = 1'b0;
    bptr = 0;
    req_data = 32'h0000_2211;
    req = 4'b0011;
    push_exp(req);
    start_frame(4'b1111, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx) || d !== e.data) begin fails++; $display("FAIL ar_regrant: got %b/%h want idx %0d/%h", g, d, e.idx, e.data); end
    finish_frame(0, 1, sh, sa, dn, dc, cl);
    req = '0;
    bptr = (e.idx + 1) % 4;
  endtask
`ifdef UART_TX_ARB_WATCHDOG_EN
  task automatic test_watchdog;
    logic [3:0] g, dn; logic [7:0] d; logic s, sh, sa, cl; int n, dc, c, errs, dones; exp_t e;
    req_data = 32'h0077_6600;
    req = 4'b0110;
    push_exp(req);
    start_frame(4'b0000, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx)) begin fails++; $display("FAIL wdg_gnt1: got %b want idx %0d", g, e.idx); end
    c = 0; errs = 0; dones = 0;
    while (errs == 0 && c < 200) begin
      @(negedge clock); c++;
      if (err === 1'b1) errs++;
      if (done !== 4'b0) dones++;
    end
    checks++; if (errs != 1 || c < 95 || c > 110) begin fails++; $display("FAIL wdg_err: %0d pulses after %0d cycles want 1 near 100", errs, c); end
    checks++; if (tx_send !== 1'b0 || dones != 0) begin fails++; $display("FAIL wdg_abort: send %b dones %0d want 0 0", tx_send, dones); end
    bptr = (e.idx + 1) % 4;
    push_exp(req);
    start_frame(4'b1111, g, d, s, n);
    e = sb.pop_front();
    checks++; if (g !== 4'(1 << e.idx) || err !== 1'b0) begin fails++; $display("FAIL wdg_next: got %b err %b want idx %0d err 0", g, err, e.idx); end
    finish_frame(0, 1, sh, sa, dn, dc, cl);
    req = '0;
  endtask
`endif
  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_withdraw;
    test_level_done;
    test_async_reset;
`ifdef UART_TX_ARB_WATCHDOG_EN
    test_watchdog;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
